// File: rtl/stream_mux_pkg.sv
// Shared constants and the round-robin pick function for stream_mux.
// Arbitration helpers are written at a fixed maximum width and cast down by the users.
package stream_mux_pkg;

    localparam int MODE_SEL  = 0;
    localparam int MODE_RR   = 1;
    localparam int MAX_N     = 16;
    localparam int MAX_SEL_W = 4;

    // One-hot grant to the first valid channel at or after ptr, wrapping modulo n.
    function automatic logic [MAX_N-1:0] rr_pick(
        input logic [MAX_N-1:0]     valid,
        input logic [MAX_SEL_W-1:0] ptr,
        input int                   n
    );
        logic [MAX_N-1:0] grant;
        logic             found;
        int               idx;
        grant = {MAX_N{1'b0}};
        found = 1'b0;
        for (int i = 0; i < MAX_N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((i < n) && !found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin arbiter for stream_mux; holds the search pointer.
// The pointer advances past the accepted channel, which may differ from this grant under a packet lock.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    input  logic [SEL_W-1:0] idx,
    output logic [N-1:0]     grant
);

    logic [SEL_W-1:0] ptr_r;

    // Combinational grant from the current requests and pointer.
    always_comb begin
        grant = N'(rr_pick(MAX_N'(req), MAX_SEL_W'(ptr_r), N));
    end

    // Pointer update: move just past the channel that was accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= {SEL_W{1'b0}};
        end else if (advance) begin
            ptr_r <= (idx == SEL_W'(N - 1)) ? {SEL_W{1'b0}} : idx + SEL_W'(1);
        end
    end

endmodule

// File: rtl/stream_mux.sv
// N-channel valid/ready stream combiner with a registered output stage.
// Optional packet lock on in_last/out_last when STREAM_MUX_LAST_LOCK_EN is defined.
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int MODE  = MODE_SEL,
    parameter int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic [N*W-1:0]   in_data,
    input  logic [SEL_W-1:0] sel,
`ifdef STREAM_MUX_LAST_LOCK_EN
    input  logic [N-1:0]     in_last,
    output logic             out_last,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_sel
);

    logic [N-1:0]     rr_grant_s;
    logic [N-1:0]     base_grant_s;
    logic [N-1:0]     grant_s;
    logic             free_s;
    logic             accept_s;
    logic [SEL_W-1:0] acc_idx_s;

    generate
        if (MODE == MODE_RR) begin : g_rr
            rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
                .clk     (clk),
                .rst     (rst),
                .req     (in_valid),
                .advance (accept_s),
                .idx     (acc_idx_s),
                .grant   (rr_grant_s)
            );
        end else begin : g_sel
            assign rr_grant_s = {N{1'b0}};
        end
    endgenerate

    // Per-beat grant: arbiter result, or decoded sel with out-of-range selecting nothing.
    always_comb begin
        base_grant_s = {N{1'b0}};
        if (MODE == MODE_RR) begin
            base_grant_s = rr_grant_s;
        end else if (32'(sel) < 32'(N)) begin
            base_grant_s[sel] = 1'b1;
        end else begin
            base_grant_s = {N{1'b0}};
        end
    end

`ifdef STREAM_MUX_LAST_LOCK_EN
    logic             lock_r;
    logic [SEL_W-1:0] lock_ch_r;

    // An unfinished packet keeps the grant on its channel until its last beat.
    always_comb begin
        grant_s = {N{1'b0}};
        if (lock_r) begin
            grant_s[lock_ch_r] = 1'b1;
        end else begin
            grant_s = base_grant_s;
        end
    end

    // Lock state and last flag follow every accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_r    <= 1'b0;
            lock_ch_r <= {SEL_W{1'b0}};
            out_last  <= 1'b0;
        end else if (accept_s) begin
            lock_r    <= ~in_last[acc_idx_s];
            lock_ch_r <= acc_idx_s;
            out_last  <= in_last[acc_idx_s];
        end
    end
`else
    // Without packet locking the per-beat grant is final.
    always_comb begin
        grant_s = base_grant_s;
    end
`endif

    // Handshake: ready only when the output register can take a beat; index from one-hot grant.
    always_comb begin
        free_s = ~out_valid | out_ready;
        if (rst) begin
            in_ready = {N{1'b0}};
        end else begin
            in_ready = grant_s & {N{free_s}};
        end
        accept_s  = |(in_valid & in_ready);
        acc_idx_s = {SEL_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            acc_idx_s = acc_idx_s | (grant_s[i] ? SEL_W'(i) : {SEL_W{1'b0}});
        end
    end

    // Output register: load on accept, clear valid on drain, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= {W{1'b0}};
            out_sel   <= {SEL_W{1'b0}};
        end else if (accept_s) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(acc_idx_s) * W +: W];
            out_sel   <= acc_idx_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux.sv
// Scoreboard bench for stream_mux: a select-mode instance (N=5) and a round-robin instance (N=4).
// A reference model predicts grants and pushes expected beats; a monitor checks the output stream.
module tb_stream_mux;
    import stream_mux_pkg::*;

    typedef struct {
        logic [7:0] d;
        int         s;
        logic       l;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  in_valid;
    logic [39:0] in_data;
    logic [2:0]  sel;
    logic        out_ready;
    logic [4:0]  in_last;

    logic [4:0]  rdy0;
    logic        ov0, ol0;
    logic [7:0]  od0;
    logic [2:0]  os0;
    logic [3:0]  rdy1;
    logic        ov1, ol1;
    logic [7:0]  od1;
    logic [1:0]  os1;

    exp_t q0[$];
    exp_t q1[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   ptr1  = 0;
    bit   lk0   = 1'b0;
    bit   lk1   = 1'b0;
    int   lc0   = 0;
    int   lc1   = 0;

    always #5 clk = ~clk;

    stream_mux #(.N(5), .W(8), .MODE(MODE_SEL)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .sel(sel),
`ifdef STREAM_MUX_LAST_LOCK_EN
        .in_last(in_last), .out_last(ol0),
`endif
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_sel(os0)
    );

    stream_mux #(.N(4), .W(8), .MODE(MODE_RR)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[3:0]), .in_ready(rdy1), .in_data(in_data[31:0]),
        .sel(sel[1:0]),
`ifdef STREAM_MUX_LAST_LOCK_EN
        .in_last(in_last[3:0]), .out_last(ol1),
`endif
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_sel(os1)
    );

`ifndef STREAM_MUX_LAST_LOCK_EN
    assign ol0 = 1'b0;
    assign ol1 = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference grant: locked channel, else decoded select, else cyclic search from ptr.
    function automatic int pick(input int mode, input int n, input logic [4:0] v, input int s,
                                input int p, input bit lk, input int lc);
        if (lk) return lc;
        if (mode == MODE_SEL) return (s < n) ? s : -1;
        for (int i = 0; i < n; i++) begin
            if (v[(p + i) % n]) return (p + i) % n;
        end
        return -1;
    endfunction

    task automatic mon(input int id, input logic ov, input logic [7:0] od, input int os, input logic ol);
        exp_t e;
        int   sz;
        sz = (id == 0) ? q0.size() : q1.size();
        chk($sformatf("out_valid%0d", id), 64'(ov), 64'(sz > 0));
        if (ov && sz > 0) begin
            if (id == 0) e = q0[0];
            else e = q1[0];
            chk($sformatf("out_data%0d", id), 64'(od), 64'(e.d));
            chk($sformatf("out_sel%0d", id), 64'(os), 64'(e.s));
`ifdef STREAM_MUX_LAST_LOCK_EN
            chk($sformatf("out_last%0d", id), 64'(ol), 64'(e.l));
`endif
            if (out_ready) begin
                if (id == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
            end
        end
    endtask

    // Monitor: compare the presented output beat against the head of each scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            mon(0, ov0, od0, int'(os0), ol0);
            mon(1, ov1, od1, int'(os1), ol1);
        end
    end

    // Reference model: after the monitor has drained, predict ready and push accepted beats.
    always @(negedge clk) begin
        int         g;
        bit         fr;
        exp_t       e;
        logic [4:0] exp5;
        logic [3:0] exp4;
        #2;
        if (rst) begin
            q0.delete();
            q1.delete();
            ptr1 = 0;
            lk0  = 1'b0;
            lk1  = 1'b0;
            chk("in_ready0_rst", 64'(rdy0), 64'd0);
            chk("in_ready1_rst", 64'(rdy1), 64'd0);
        end else begin
            g    = pick(MODE_SEL, 5, in_valid, int'(sel), 0, lk0, lc0);
            fr   = (q0.size() == 0);
            exp5 = (g >= 0 && fr) ? (5'd1 << g) : 5'd0;
            chk("in_ready0", 64'(rdy0), 64'(exp5));
            if (g >= 0 && fr && in_valid[g]) begin
                e.d = in_data[g*8 +: 8];
                e.s = g;
                e.l = in_last[g];
                q0.push_back(e);
`ifdef STREAM_MUX_LAST_LOCK_EN
                lk0 = !in_last[g];
                lc0 = g;
`endif
            end
            g    = pick(MODE_RR, 4, {1'b0, in_valid[3:0]}, 0, ptr1, lk1, lc1);
            fr   = (q1.size() == 0);
            exp4 = (g >= 0 && fr) ? (4'd1 << g) : 4'd0;
            chk("in_ready1", 64'(rdy1), 64'(exp4));
            if (g >= 0 && fr && in_valid[g]) begin
                e.d = in_data[g*8 +: 8];
                e.s = g;
                e.l = in_last[g];
                q1.push_back(e);
                ptr1 = (g + 1) % 4;
`ifdef STREAM_MUX_LAST_LOCK_EN
                lk1 = !in_last[g];
                lc1 = g;
`endif
            end
        end
    end

    function automatic logic [39:0] rnd40();
        return 40'({$urandom(), $urandom()});
    endfunction

    task automatic drive(input logic [4:0] v, input logic [39:0] d, input logic [2:0] s,
                         input logic r, input logic [4:0] l);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        sel       = s;
        out_ready = r;
        in_last   = l;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid0"}, 64'(ov0), 64'd0);
        chk({tag, "_out_data0"}, 64'(od0), 64'd0);
        chk({tag, "_out_sel0"}, 64'(os0), 64'd0);
        chk({tag, "_in_ready0"}, 64'(rdy0), 64'd0);
        chk({tag, "_out_valid1"}, 64'(ov1), 64'd0);
        chk({tag, "_out_data1"}, 64'(od1), 64'd0);
        chk({tag, "_in_ready1"}, 64'(rdy1), 64'd0);
        chk({tag, "_out_last0"}, 64'(ol0), 64'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 5'h1F;
        #1;
        chk_reset_state("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [39:0] d;
        rst       = 1'b1;
        in_valid  = 5'h1F;
        in_data   = rnd40();
        sel       = 3'd0;
        out_ready = 1'b0;
        in_last   = 5'd0;
        #1;
        chk_reset_state("rst");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        d = rnd40();
        d[23:16] = 8'hA5;
        drive(5'b00100, d, 3'd2, 1'b1, 5'h1F);
        drive(5'b00000, rnd40(), 3'd2, 1'b1, 5'h1F);
        repeat (2) drive(5'h1F, rnd40(), 3'd5, 1'b1, 5'h1F);

        drive(5'h1F, rnd40(), 3'd1, 1'b1, 5'h1F);
        repeat (3) drive(5'h1F, rnd40(), 3'($urandom_range(0, 7)), 1'b0, 5'h1F);
        drive(5'h1F, rnd40(), 3'd3, 1'b1, 5'h1F);

        repeat (10) drive(5'h1F, rnd40(), 3'd0, 1'b1, 5'h1F);
        repeat (2) drive(5'b00000, rnd40(), 3'd0, 1'b1, 5'h1F);
        drive(5'b00001, rnd40(), 3'd0, 1'b1, 5'h1F);
        repeat (4) drive(5'b01001, rnd40(), 3'd0, 1'b1, 5'h1F);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) pulse_reset();
            drive(5'($urandom()), rnd40(), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 3) != 0), 5'($urandom() | $urandom()));
        end

`ifdef STREAM_MUX_LAST_LOCK_EN
        pulse_reset();
        drive(5'b00110, rnd40(), 3'd1, 1'b1, 5'b00100);
        drive(5'b00110, rnd40(), 3'd2, 1'b1, 5'b00100);
        drive(5'b00110, rnd40(), 3'd2, 1'b1, 5'b00110);
        repeat (2) drive(5'b00110, rnd40(), 3'd2, 1'b1, 5'b00110);
`endif

        repeat (4) drive(5'b00000, rnd40(), 3'd0, 1'b1, 5'h1F);
        @(negedge clk);
        #5;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
